// File: rtl/half_adder_pkg.sv
`default_nettype none
// ============================================================================
// half_adder_pkg : default sizing and lane result type for half_adder
// Revision 1.0
// ============================================================================
package half_adder_pkg;

  localparam int HA_WIDTH_DEF = 1;
  localparam int HA_CNT_W_DEF = 16;

  typedef struct packed {
    logic carry;
    logic sum;
  } lane_res_t;

  function automatic lane_res_t ha_eval(input logic i_a, input logic i_b);
    lane_res_t r;
    r.sum   = i_a ^ i_b;
    r.carry = i_a & i_b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_adder_cell.sv
`default_nettype none
// ============================================================================
// half_adder_cell : one combinational 1-bit half-adder lane
// Revision 1.0
// ============================================================================
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output lane_res_t res
);

  assign res = ha_eval(a, b);

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// half_adder : WIDTH independent half-adder lanes, comb + registered outputs;
// optional saturating stats counters with macro HALF_ADDER_STATS_EN.
// Revision 1.0
// ============================================================================
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEF,
  parameter int CNT_W = HA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
`ifdef HALF_ADDER_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count,
`endif
  output logic [WIDTH-1:0] sum_comb,
  output logic [WIDTH-1:0] carry_comb,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 4 || CNT_W > 32) begin : g_param_err
    $error("half_adder: WIDTH must be 1..64 and CNT_W 4..32");
  end

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lane_res_t w_res;
    half_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .res (w_res)
    );
    assign w_sum[i]   = w_res.sum;
    assign w_carry[i] = w_res.carry;
  end

  // Data registers only load on in_valid, so junk on idle inputs never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign sum_comb   = w_sum;
  assign carry_comb = w_carry;
  assign sum        = r_sum;
  assign carry      = r_carry;
  assign out_valid  = r_valid;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_carry_count;

  // Clear outranks increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count    <= '0;
      r_carry_count <= '0;
    end else if (stats_clr) begin
      r_op_count    <= '0;
      r_carry_count <= '0;
    end else if (in_valid) begin
      if (r_op_count != '1)
        r_op_count <= r_op_count + C_ONE;
      if ((|w_carry) && (r_carry_count != '1))
        r_carry_count <= r_carry_count + C_ONE;
    end
  end

  assign op_count    = r_op_count;
  assign carry_count = r_carry_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
// tb_half_adder : directed self-checking bench with result scoreboard
// Revision 1.0
// ============================================================================
module tb_half_adder;

  localparam int W  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0] carry;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum_comb, carry_comb, sum, carry;
  logic         out_valid;
`ifdef HALF_ADDER_STATS_EN
  logic          stats_clr = 1'b0;
  logic [CW-1:0] op_count, carry_count;
  int            m_ops = 0;
  int            m_cars = 0;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic [W-1:0] m_sum   = '0;
  logic [W-1:0] m_carry = '0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
`ifdef HALF_ADDER_STATS_EN
    .stats_clr   (stats_clr),
    .op_count    (op_count),
    .carry_count (carry_count),
`endif
    .sum_comb    (sum_comb),
    .carry_comb  (carry_comb),
    .sum         (sum),
    .carry       (carry),
    .out_valid   (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum"},   32'(sum),   32'(m_sum));
    check({tag, "_carry"}, 32'(carry), 32'(m_carry));
    check({tag, "_excl"},  32'(sum & carry), 32'(0));
`ifdef HALF_ADDER_STATS_EN
    check({tag, "_ops"},  32'(op_count),    32'(m_ops));
    check({tag, "_cars"}, 32'(carry_count), 32'(m_cars));
`endif
  endtask

  // One cycle: drive at negedge, check comb, then check registered after posedge.
  task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic iv, input logic iclr);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; in_valid = iv;
`ifdef HALF_ADDER_STATS_EN
    stats_clr = iclr;
    if (iclr) begin
      m_ops = 0; m_cars = 0;
    end else if (iv) begin
      if (m_ops < 2**CW - 1) m_ops++;
      if ((|(ia & ib)) && m_cars < 2**CW - 1) m_cars++;
    end
`endif
    #1;
    check("sum_comb",   32'(sum_comb),   32'(ia ^ ib));
    check("carry_comb", 32'(carry_comb), 32'(ia & ib));
    if (iv) q.push_back('{carry: ia & ib, sum: ia ^ ib});
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(iv));
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'(q.size()), 32'(1));
      end else begin
        e = q.pop_front();
        m_sum = e.sum;
        m_carry = e.carry;
      end
    end
    check_regs("reg");
`ifdef HALF_ADDER_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'(0));
    check_regs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Single-lane truth table on lane 0.
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0001, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);

    // Idle with carry-producing inputs: registers hold.
    step(4'b0000, 4'b0001, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 1'b0, 1'b0);

    // Multi-lane, no inter-lane carry.
    step(4'b1100, 4'b1010, 1'b1, 1'b0);
    step(4'b1111, 4'b0001, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      step(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Mid-stream reset after a carry has been registered.
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_carry", 32'(carry),     32'(0));
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_sum",   32'(sum),       32'(0));
    q.delete();
    m_sum = '0;
    m_carry = '0;
`ifdef HALF_ADDER_STATS_EN
    m_ops = 0;
    m_cars = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, 4'b0011, 1'b1, 1'b0);

`ifdef HALF_ADDER_STATS_EN
    repeat (20) step(4'b0001, 4'b0001, 1'b1, 1'b0);
    check("ops_sat",  32'(op_count),    32'(15));
    check("cars_sat", 32'(carry_count), 32'(15));
    step(4'b0001, 4'b0001, 1'b1, 1'b1);
    check("ops_clr",  32'(op_count),    32'(0));
    check("cars_clr", 32'(carry_count), 32'(0));
`endif

    check("sb_empty", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-adder lanes, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters, legal range 4..32.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port a, input, WIDTH: addend A, one bit per lane.
REQ-006 Port b, input, WIDTH: addend B, one bit per lane.
REQ-007 Port in_valid, input, 1: qualifies a and b in the current cycle.
REQ-008 Port sum_comb, output, WIDTH: combinational lane sum, a XOR b.
REQ-009 Port carry_comb, output, WIDTH: combinational lane carry, a AND b.
REQ-010 Port sum, output, WIDTH: registered lane sum.
REQ-011 Port carry, output, WIDTH: registered lane carry.
REQ-012 Port out_valid, output, 1: registered copy of in_valid, aligned with sum and carry.
REQ-013 Port stats_clr, input, 1: synchronous clear of the statistics counters; present only with HALF_ADDER_STATS_EN.
REQ-014 Port op_count, output, CNT_W: number of accepted operations; present only with HALF_ADDER_STATS_EN.
REQ-015 Port carry_count, output, CNT_W: number of accepted operations with any carry bit set; present only with HALF_ADDER_STATS_EN.

Function
REQ-016 sum_comb[i] SHALL equal a[i] XOR b[i], and carry_comb[i] SHALL equal a[i] AND b[i], with zero latency and independent of in_valid.
REQ-017 Lanes SHALL be independent: no carry propagates between lanes.
REQ-018 On each rising edge with in_valid=1, sum and carry SHALL load sum_comb and carry_comb, giving a latency of exactly 1 cycle.
REQ-019 On each rising edge with in_valid=0, sum and carry SHALL hold their previous values.
REQ-020 out_valid SHALL equal in_valid delayed by one cycle.
REQ-021 For any lane, the pair (carry, sum) SHALL equal the 2-bit arithmetic sum a+b, so carry and sum are never both 1.
REQ-022 op_count SHALL increment by 1 on each edge with in_valid=1.
REQ-023 carry_count SHALL increment by 1 on each edge with in_valid=1 and any bit of carry_comb set.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 When stats_clr and an increment occur in the same cycle, stats_clr SHALL win and the counter SHALL become 0.
REQ-026 X or Z on a or b while in_valid=0 SHALL NOT affect any register.

Reset
REQ-027 While rst=1, sum, carry, out_valid, op_count and carry_count SHALL be 0, asynchronously, without waiting for a clock edge.
REQ-028 sum_comb and carry_comb SHALL NOT depend on rst.
REQ-029 Reset asserted mid-stream SHALL discard any in-flight result; the first edge after rst deasserts SHALL behave as a normal cycle.

Configuration
REQ-030 With macro HALF_ADDER_STATS_EN defined, the statistics logic and ports (stats_clr, op_count, carry_count) SHALL be compiled in.
REQ-031 Without HALF_ADDER_STATS_EN, those ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants and a lane result typedef containing sum and carry bits.
REQ-033 Sub-module half_adder_cell SHALL implement one combinational 1-bit lane and be instantiated WIDTH times with a generate loop.

Verification
REQ-034 Scenario 1: WIDTH=1, in_valid=1, apply (a,b) = 00, 10, 01, 11 in turn. Required: (sum,carry) = 00, 10, 10, 01 combinationally at once, and on the registered outputs one cycle later.
REQ-035 Scenario 2: apply a=1, b=1 with in_valid=0. Required: carry_comb=1 at once; sum, carry and out_valid unchanged; op_count unchanged.
REQ-036 Scenario 3: WIDTH=4, a=4'b1100, b=4'b1010. Required: sum=4'b0110 and carry=4'b1000, with no inter-lane carry.
REQ-037 Scenario 4: assert rst mid-stream after a=1, b=1 has been registered. Required: carry=0 and out_valid=0 immediately, before the next clock edge.
REQ-038 Scenario 5 (HALF_ADDER_STATS_EN, CNT_W=4): apply 20 valid operations with a=b=1. Required: op_count=15 and carry_count=15 (saturated); then stats_clr=1 together with in_valid=1 gives 0 for both counters.
